// File: rtl/mem_resp_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and counter widths.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } memSize_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } respState_e;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned STAT_W     = 16;

endpackage

// File: rtl/mem_responder_if.sv
// Req/Ready handshake bundle between the datapath (master) and mem_responder (slave).
// MEM_RESP_STATS_EN adds the ReadCount/WriteCount/ErrorCount statistics outputs.
interface mem_responder_if;
`ifdef MEM_RESP_STATS_EN
    import mem_resp_pkg::*;
`endif

    logic        Req;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        Unsigned;
    logic        Busy;
    logic        Ready;
    logic [31:0] ReadData;
    logic        AddrError;
`ifdef MEM_RESP_STATS_EN
    logic [STAT_W-1:0] ReadCount;
    logic [STAT_W-1:0] WriteCount;
    logic [STAT_W-1:0] ErrorCount;
`endif

    modport master (
        output Req, Address, WriteData, MemWrite, MemRead, Size, Unsigned,
        input  Busy, Ready, ReadData, AddrError
`ifdef MEM_RESP_STATS_EN
        , input ReadCount, WriteCount, ErrorCount
`endif
    );

    modport slave (
        input  Req, Address, WriteData, MemWrite, MemRead, Size, Unsigned,
        output Busy, Ready, ReadData, AddrError
`ifdef MEM_RESP_STATS_EN
        , output ReadCount, WriteCount, ErrorCount
`endif
    );

endinterface

// File: rtl/mem_resp_lane_align.sv
// Little-endian lane steering: load extract/extend and store byte-enable + merged word.
module mem_resp_lane_align
    import mem_resp_pkg::*;
(
    input  memSize_e    size,
    input  logic        isUnsigned,
    input  logic [1:0]  addrLo,
    input  logic [31:0] memWord,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord,
    output logic [3:0]  byteEn
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] storeLanes;

    always_comb begin
        laneByte   = memWord[{addrLo, 3'b000} +: 8];
        laneHalf   = memWord[{addrLo[1], 4'b0000} +: 16];
        loadData   = '0;
        byteEn     = '0;
        storeLanes = storeData;
        case (size)
            SZ_BYTE: begin
                loadData   = isUnsigned ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
                byteEn     = 4'b0001 << addrLo;
                storeLanes = {4{storeData[7:0]}};
            end
            SZ_HALF: begin
                loadData   = isUnsigned ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
                byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
                storeLanes = {2{storeData[15:0]}};
            end
            SZ_WORD: begin
                loadData = memWord;
                byteEn   = 4'b1111;
            end
            default: ;
        endcase

        // Data is replicated across lanes so the enable mask alone picks the target bytes.
        mergedWord = memWord;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byteEn[i]) mergedWord[8*i +: 8] = storeLanes[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one load/store, waits WAIT_STATES cycles, then accesses RAM.
// Optional MEM_RESP_STATS_EN adds saturating read/write/error counters.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic            Clk,
    input logic            Reset,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]           mem [DEPTH_WORDS];
    respState_e            state;
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic [31:0]           latAddr;
    logic [31:0]           latData;
    logic                  latWrite;
    logic                  latRead;
    memSize_e              latSize;
    logic                  latUnsigned;

    logic                  busyQ;
    logic                  readyQ;
    logic [31:0]           readDataQ;
    logic                  addrErrQ;

    logic [IDX_W-1:0]      wordIdx;
    logic [31:0]           memWord;
    logic [31:0]           loadData;
    logic [31:0]           mergedWord;
    logic [3:0]            byteEn;
    logic                  reqErr;
    logic                  memWe;

    assign wordIdx = latAddr[IDX_W+1:2];
    assign memWord = mem[wordIdx];

    mem_resp_lane_align uAlign (
        .size       (latSize),
        .isUnsigned (latUnsigned),
        .addrLo     (latAddr[1:0]),
        .memWord    (memWord),
        .storeData  (latData),
        .loadData   (loadData),
        .mergedWord (mergedWord),
        .byteEn     (byteEn)
    );

    always_comb begin
        reqErr = 1'b0;
        if (latSize == SZ_HALF && latAddr[0])                     reqErr = 1'b1;
        if (latSize == SZ_WORD && latAddr[1:0] != 2'b00)          reqErr = 1'b1;
        if (latSize == SZ_ILLEGAL)                                reqErr = 1'b1;
        if (latRead && latWrite)                                  reqErr = 1'b1;
        if ({2'b00, latAddr[31:2]} >= 32'(DEPTH_WORDS))           reqErr = 1'b1;
    end

    // The store commits only in RESP; reset forces IDLE, so an aborted store never lands.
    assign memWe = (state == S_RESP) && latWrite && !reqErr;

    always_ff @(posedge Clk) begin
        if (memWe) mem[wordIdx] <= mergedWord;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            waitCnt     <= '0;
            latAddr     <= '0;
            latData     <= '0;
            latWrite    <= 1'b0;
            latRead     <= 1'b0;
            latSize     <= SZ_BYTE;
            latUnsigned <= 1'b0;
            busyQ       <= 1'b0;
            readyQ      <= 1'b0;
            readDataQ   <= '0;
            addrErrQ    <= 1'b0;
        end else begin
            readyQ    <= 1'b0;
            readDataQ <= '0;
            addrErrQ  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Req && (bus.MemRead || bus.MemWrite)) begin
                        latAddr     <= bus.Address;
                        latData     <= bus.WriteData;
                        latWrite    <= bus.MemWrite;
                        latRead     <= bus.MemRead;
                        latSize     <= memSize_e'(bus.Size);
                        latUnsigned <= bus.Unsigned;
                        waitCnt     <= WAIT_CNT_W'(WAIT_STATES);
                        busyQ       <= 1'b1;
                        state       <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    waitCnt <= waitCnt - 1'b1;
                    if (waitCnt <= 1) state <= S_RESP;
                end
                S_RESP: begin
                    readyQ   <= 1'b1;
                    busyQ    <= 1'b0;
                    addrErrQ <= reqErr;
                    if (latRead && !reqErr) readDataQ <= loadData;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy      = busyQ;
    assign bus.Ready     = readyQ;
    assign bus.ReadData  = readDataQ;
    assign bus.AddrError = addrErrQ;

`ifdef MEM_RESP_STATS_EN
    logic [STAT_W-1:0] readCnt;
    logic [STAT_W-1:0] writeCnt;
    logic [STAT_W-1:0] errCnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            readCnt  <= '0;
            writeCnt <= '0;
            errCnt   <= '0;
        end else if (state == S_RESP) begin
            if (reqErr) begin
                if (errCnt != '1) errCnt <= errCnt + 1'b1;
            end else if (latWrite) begin
                if (writeCnt != '1) writeCnt <= writeCnt + 1'b1;
            end else begin
                if (readCnt != '1) readCnt <= readCnt + 1'b1;
            end
        end
    end

    assign bus.ReadCount  = readCnt;
    assign bus.WriteCount = writeCnt;
    assign bus.ErrorCount = errCnt;
`endif

endmodule
